// File: rtl/i2c_pkg.sv
// Shared I2C datapath constants: shift direction
// selectors and the shift-register state encoding.
package i2c_pkg;

  localparam bit SHIFT_MSB_FIRST = 1'b1;
  localparam bit SHIFT_LSB_FIRST = 1'b0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_e;

endpackage

// File: rtl/counter_param.sv
// Up counter with sync clear/zero and increment.
// Ports: clk, rst_ (async low), clear, zero, inc, cnt.
module counter_param #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             clear,
  input  logic             zero,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt <= '0;
    end else if (clear || zero) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/register_shift_param.sv
// Bidirectional I2C byte shift register: load, shift out
// ser_out while sampling ser_in; bit_cnt/busy/done status.
module register_shift_param
  import i2c_pkg::*;
#(
  parameter int                     reg_width   = 8,
  parameter logic [reg_width-1:0]   reset_value = '0,
  parameter bit                     msb_first   = SHIFT_MSB_FIRST,
  localparam int                    CNT_W       = $clog2(reg_width + 1)
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 clear,
  input  logic                 load,
  input  logic [reg_width-1:0] reg_in,
  input  logic                 shift_en,
  input  logic                 ser_in,
  output logic                 ser_out,
  output logic [reg_width-1:0] reg_out,
  output logic [CNT_W-1:0]     bit_cnt,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(reg_width - 1);

  shift_state_e         state;
  logic [reg_width-1:0] data;
  logic                 do_shift;

  // Shift only while a transfer is active and nothing
  // of higher priority claims the cycle.
  assign do_shift = shift_en && (state == ST_SHIFT)
                    && !clear && !load;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= ST_IDLE;
      data  <= reset_value;
      done  <= 1'b0;
    end else if (clear) begin
      state <= ST_IDLE;
      data  <= reset_value;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state <= ST_SHIFT;
        data  <= reg_in;
      end else if (do_shift) begin
        if (msb_first) begin
          data <= {data[reg_width-2:0], ser_in};
        end else begin
          data <= {ser_in, data[reg_width-1:1]};
        end
        if (bit_cnt == LAST) begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
      end
    end
  end

  counter_param #(
    .WIDTH (CNT_W)
  ) u_bit_cnt (
    .clk   (clk),
    .rst_  (rst_),
    .clear (clear),
    .zero  (load),
    .inc   (do_shift),
    .cnt   (bit_cnt)
  );

  assign busy    = (state == ST_SHIFT);
  assign reg_out = data;
  assign ser_out = msb_first ? data[reg_width-1] : data[0];

endmodule

// File: tb/tb_register_shift_param.sv
// Directed bench for register_shift_param: MSB-first and
// LSB-first instances driven from one stimulus sequence.
module tb_register_shift_param;

  logic       clk = 1'b0;
  logic       rst_;
  logic       clear;
  logic       load;
  logic [7:0] reg_in;
  logic       shift_en;
  logic       ser_in;

  logic       so_m, so_l;
  logic [7:0] ro_m, ro_l;
  logic [3:0] bc_m, bc_l;
  logic       busy_m, busy_l;
  logic       done_m, done_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register_shift_param #(
    .reg_width   (8),
    .reset_value (8'h00),
    .msb_first   (1'b1)
  ) dut_m (
    .clk      (clk),
    .rst_     (rst_),
    .clear    (clear),
    .load     (load),
    .reg_in   (reg_in),
    .shift_en (shift_en),
    .ser_in   (ser_in),
    .ser_out  (so_m),
    .reg_out  (ro_m),
    .bit_cnt  (bc_m),
    .busy     (busy_m),
    .done     (done_m)
  );

  register_shift_param #(
    .reg_width   (8),
    .reset_value (8'h5A),
    .msb_first   (1'b0)
  ) dut_l (
    .clk      (clk),
    .rst_     (rst_),
    .clear    (clear),
    .load     (load),
    .reg_in   (reg_in),
    .shift_en (shift_en),
    .ser_in   (ser_in),
    .ser_out  (so_l),
    .reg_out  (ro_l),
    .bit_cnt  (bc_l),
    .busy     (busy_l),
    .done     (done_l)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sh(input logic b);
    ser_in   = b;
    shift_en = 1'b1;
    tick();
    shift_en = 1'b0;
  endtask

  task automatic ld(input logic [7:0] v);
    reg_in = v;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_so;
    logic [7:0] sin;
    exp_so   = 8'hA5;
    sin      = 8'b1011_0011;
    rst_     = 1'b0;
    clear    = 1'b0;
    load     = 1'b0;
    reg_in   = 8'h00;
    shift_en = 1'b0;
    ser_in   = 1'b0;
    tick();
    tick();
    chk("rst_ro_m", 32'(ro_m), 32'h00);
    chk("rst_ro_l", 32'(ro_l), 32'h5A);
    chk("rst_bc", 32'(bc_m), 32'd0);
    chk("rst_busy", 32'(busy_m), 32'd0);
    chk("rst_done", 32'(done_m), 32'd0);
    rst_ = 1'b1;
    tick();

    // 1: MSB first, A5 out, B3 in
    ld(8'hA5);
    chk("t1_busy", 32'(busy_m), 32'd1);
    chk("t1_bc0", 32'(bc_m), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_so%0d", i), 32'(so_m), 32'(exp_so[7-i]));
      sh(sin[7-i]);
      if (i < 7) chk($sformatf("t1_nodone%0d", i), 32'(done_m), 32'd0);
    end
    chk("t1_done", 32'(done_m), 32'd1);
    chk("t1_ro", 32'(ro_m), 32'hB3);
    chk("t1_bc8", 32'(bc_m), 32'd8);
    chk("t1_idle", 32'(busy_m), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(done_m), 32'd0);
    chk("t1_hold", 32'(ro_m), 32'hB3);

    // 5: shift while idle
    sh(1'b0);
    chk("t5_ro", 32'(ro_m), 32'hB3);
    chk("t5_bc", 32'(bc_m), 32'd8);
    chk("t5_done", 32'(done_m), 32'd0);

    // 2: LSB first, zeros in
    ld(8'hA5);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_so%0d", i), 32'(so_l), 32'(exp_so[i]));
      sh(1'b0);
    end
    chk("t2_ro", 32'(ro_l), 32'h00);
    chk("t2_done", 32'(done_l), 32'd1);
    chk("t2_bc", 32'(bc_l), 32'd8);

    // 3: reload while busy
    ld(8'hFF);
    sh(1'b1);
    sh(1'b1);
    sh(1'b1);
    chk("t3_bc3", 32'(bc_m), 32'd3);
    ld(8'h0F);
    chk("t3_bc", 32'(bc_m), 32'd0);
    chk("t3_busy", 32'(busy_m), 32'd1);
    chk("t3_so", 32'(so_m), 32'd0);
    chk("t3_done", 32'(done_m), 32'd0);
    sh(1'b0);
    chk("t3_bc1", 32'(bc_m), 32'd1);

    // 4: load and shift together
    reg_in   = 8'h3C;
    ser_in   = 1'b1;
    load     = 1'b1;
    shift_en = 1'b1;
    tick();
    load     = 1'b0;
    shift_en = 1'b0;
    chk("t4_ro", 32'(ro_m), 32'h3C);
    chk("t4_bc", 32'(bc_m), 32'd0);
    chk("t4_so", 32'(so_m), 32'd0);

    // 6a: async reset mid-transfer
    for (int i = 0; i < 4; i++) sh(1'b1);
    chk("t6_bc4", 32'(bc_m), 32'd4);
    @(negedge clk);
    rst_ = 1'b0;
    #1;
    chk("t6_rst_ro", 32'(ro_m), 32'h00);
    chk("t6_rst_ro_l", 32'(ro_l), 32'h5A);
    chk("t6_rst_bc", 32'(bc_m), 32'd0);
    chk("t6_rst_busy", 32'(busy_m), 32'd0);
    chk("t6_rst_so", 32'(so_m), 32'd0);
    tick();
    rst_ = 1'b1;
    tick();

    // 6b: clear at shift 7
    ld(8'hC3);
    for (int i = 0; i < 6; i++) sh(1'b1);
    clear = 1'b1;
    sh(1'b1);
    clear = 1'b0;
    chk("t6_clr_ro", 32'(ro_m), 32'h00);
    chk("t6_clr_bc", 32'(bc_m), 32'd0);
    chk("t6_clr_busy", 32'(busy_m), 32'd0);
    chk("t6_clr_done", 32'(done_m), 32'd0);

    // clear on the final shift suppresses done
    ld(8'hFF);
    for (int i = 0; i < 7; i++) sh(1'b1);
    clear = 1'b1;
    sh(1'b1);
    clear = 1'b0;
    chk("t6_sup_done", 32'(done_m), 32'd0);
    chk("t6_sup_ro", 32'(ro_m), 32'h00);
    tick();
    chk("t6_sup_done2", 32'(done_m), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
